// File: rtl/pipeline_rr_arbiter_if.sv
// Stream bundle for pipeline_rr_arbiter: NumReq request streams in, one merged stream out.
// The slave modport is the arbiter's view; master is the surrounding logic that drives it.
interface pipeline_rr_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 8
);
    localparam int SrcWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0][DataWidth-1:0] data_in_i;
    logic [NumReq-1:0]                data_in_valid_i;
    logic [NumReq-1:0]                data_in_last_i;
    logic [NumReq-1:0]                data_in_ready_o;
    logic [DataWidth-1:0]             data_out_o;
    logic                             data_out_valid_o;
    logic                             data_out_ready_i;
    logic                             data_out_last_o;
    logic [SrcWidth-1:0]              data_out_src_o;

    modport master (
        output data_in_i, data_in_valid_i, data_in_last_i, data_out_ready_i,
        input  data_in_ready_o, data_out_o, data_out_valid_o, data_out_last_o, data_out_src_o
    );

    modport slave (
        input  data_in_i, data_in_valid_i, data_in_last_i, data_out_ready_i,
        output data_in_ready_o, data_out_o, data_out_valid_o, data_out_last_o, data_out_src_o
    );
endinterface

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter merging NumReq valid/ready streams into one registered output stream.
// Define PIPELINE_RR_ARBITER_LOCK_EN to keep multi-beat packets from one requester contiguous.
module pipeline_rr_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 8
) (
    input logic                  clk_i,
    input logic                  rst_i,
    pipeline_rr_arbiter_if.slave bus
);
    localparam int SrcWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
    typedef logic [SrcWidth-1:0] idx_t;

    logic                 valid_q;
    logic [DataWidth-1:0] data_q;
    logic                 last_q;
    idx_t                 src_q;
    idx_t                 ptr_q, ptr_d;

    logic                 loadEn;
    logic [NumReq-1:0]    grant;
    idx_t                 grantIdx;
    logic [NumReq-1:0]    readyInt;
    logic                 xfer;
    logic                 xferLast;
    logic [DataWidth-1:0] selData;
    logic                 lockActive;
    idx_t                 lockSel;

    function automatic idx_t nextIdx(input idx_t i);
        if (int'(i) >= NumReq - 1) begin
            return '0;
        end
        return i + idx_t'(1);
    endfunction

    assign loadEn = ~valid_q | bus.data_out_ready_i;

    // Rotating the doubled request vector by ptr puts the search start at bit 0.
    always_comb begin
        logic [2*NumReq-1:0] rot;
        logic                found;
        int                  offset;
        int                  sum;
        rot      = {bus.data_in_valid_i, bus.data_in_valid_i} >> ptr_q;
        found    = 1'b0;
        offset   = 0;
        sum      = 0;
        grant    = '0;
        grantIdx = '0;
        if (lockActive) begin
            grantIdx = lockSel;
            for (int k = 0; k < NumReq; k++) begin
                grant[k] = (idx_t'(k) == lockSel);
            end
        end else if (NumReq == 1) begin
            grant[0] = 1'b1;
        end else begin
            for (int k = NumReq - 1; k >= 0; k--) begin
                if (rot[k]) begin
                    found  = 1'b1;
                    offset = k;
                end
            end
            sum = int'(ptr_q) + offset;
            if (sum >= NumReq) begin
                sum = sum - NumReq;
            end
            grantIdx = idx_t'(sum);
            for (int k = 0; k < NumReq; k++) begin
                grant[k] = found && (idx_t'(k) == grantIdx);
            end
        end
    end

    assign readyInt            = grant & {NumReq{loadEn & ~rst_i}};
    assign bus.data_in_ready_o = readyInt;

    always_comb begin
        xfer     = 1'b0;
        xferLast = 1'b0;
        selData  = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (bus.data_in_valid_i[k] && readyInt[k]) begin
                xfer     = 1'b1;
                xferLast = xferLast | bus.data_in_last_i[k];
                selData  = selData | bus.data_in_i[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            src_q   <= '0;
        end else if (loadEn) begin
            valid_q <= xfer;
            if (xfer) begin
                data_q <= selData;
                last_q <= xferLast;
                src_q  <= grantIdx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef PIPELINE_RR_ARBITER_LOCK_EN
    typedef enum logic {FREE, LOCKED} lockState_e;

    lockState_e state_q, state_d;
    idx_t       lockIdx_q, lockIdx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FREE;
            lockIdx_q <= '0;
        end else begin
            state_q   <= state_d;
            lockIdx_q <= lockIdx_d;
        end
    end

    // The pointer only moves once a whole packet has gone through.
    always_comb begin
        state_d   = state_q;
        lockIdx_d = lockIdx_q;
        ptr_d     = ptr_q;
        case (state_q)
            FREE: begin
                if (xfer) begin
                    if (xferLast) begin
                        ptr_d = nextIdx(grantIdx);
                    end else begin
                        state_d   = LOCKED;
                        lockIdx_d = grantIdx;
                    end
                end
            end
            LOCKED: begin
                if (xfer && xferLast) begin
                    state_d = FREE;
                    ptr_d   = nextIdx(lockIdx_q);
                end
            end
            default: state_d = FREE;
        endcase
    end

    assign lockActive = (state_q == LOCKED);
    assign lockSel    = lockIdx_q;
`else
    assign lockActive = 1'b0;
    assign lockSel    = '0;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = nextIdx(grantIdx);
        end
    end
`endif

    assign bus.data_out_o       = data_q;
    assign bus.data_out_valid_o = valid_q;
    assign bus.data_out_last_o  = last_q;
    assign bus.data_out_src_o   = src_q;
endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Directed bench for pipeline_rr_arbiter: per-requester source queues drive the inputs,
// expected beats go into a scoreboard and are compared as the output stream pops them.
module tb_pipeline_rr_arbiter;
    localparam int NumReq    = 4;
    localparam int DataWidth = 8;
    localparam int SrcWidth  = 2;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 last;
    } beat_t;

    typedef struct packed {
        logic [SrcWidth-1:0]  src;
        logic [DataWidth-1:0] data;
        logic                 last;
    } outBeat_t;

    logic     clk = 1'b0;
    logic     rst;
    int       checks = 0;
    int       errors = 0;
    bit       lockWatch = 1'b0;
    beat_t    srcQ [NumReq][$];
    outBeat_t expQ [$];

    pipeline_rr_arbiter_if #(.NumReq(NumReq), .DataWidth(DataWidth)) bus ();

    pipeline_rr_arbiter #(.NumReq(NumReq), .DataWidth(DataWidth)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushSrc(input int i, input logic [DataWidth-1:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        srcQ[i].push_back(b);
    endtask

    task automatic expectBeat(input logic [SrcWidth-1:0] src, input logic [DataWidth-1:0] data,
                              input logic last);
        outBeat_t e;
        e.src  = src;
        e.data = data;
        e.last = last;
        expQ.push_back(e);
    endtask

    function automatic bit pending();
        for (int i = 0; i < NumReq; i++) begin
            if (srcQ[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < NumReq; i++) begin
            if (srcQ[i].size() > 0) begin
                bus.data_in_valid_i[i] = 1'b1;
                bus.data_in_i[i]       = srcQ[i][0].data;
                bus.data_in_last_i[i]  = srcQ[i][0].last;
            end else begin
                bus.data_in_valid_i[i] = 1'b0;
                bus.data_in_i[i]       = '0;
                bus.data_in_last_i[i]  = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        outBeat_t obs;
        outBeat_t exp;
        obs = {bus.data_out_src_o, bus.data_out_o, bus.data_out_last_o};
        checkVal("scoreboard_has_entry", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkVal("out_beat", 32'(obs), 32'(exp));
        end
    endtask

    // Sample at the falling edge, advance through the rising edge, then retire accepted beats.
    task automatic tick();
        logic [NumReq-1:0] took;
        @(negedge clk);
        took = bus.data_in_valid_i & bus.data_in_ready_o;
        if (bus.data_out_valid_o && bus.data_out_ready_i && !rst) checkOutput();
`ifdef PIPELINE_RR_ARBITER_LOCK_EN
        if (lockWatch && srcQ[2].size() > 0)
            checkVal("lock_blocks_req0", 32'(bus.data_in_ready_o[0]), 32'd0);
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < NumReq; i++) begin
            if (took[i]) void'(srcQ[i].pop_front());
        end
        applyStimulus();
    endtask

    task automatic drain(input string tag, input int maxCycles);
        int n = 0;
        while ((pending() || expQ.size() > 0 || bus.data_out_valid_o) && n < maxCycles) begin
            tick();
            n++;
        end
        checkVal({tag, "_drained"},
                 32'(pending() || expQ.size() > 0 || bus.data_out_valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] held;

        rst                  = 1'b1;
        bus.data_out_ready_i = 1'b1;
        bus.data_in_valid_i  = '0;
        bus.data_in_i        = '0;
        bus.data_in_last_i   = '0;

        // Reset with every requester valid, then rotation with a stall in the middle
        for (int i = 0; i < NumReq; i++) pushSrc(i, 8'(8'hA0 + i), 1'b1);
        for (int i = 0; i < NumReq; i++) pushSrc(i, 8'(8'hB0 + i), 1'b1);
        for (int i = 0; i < NumReq; i++) expectBeat(2'(i), 8'(8'hA0 + i), 1'b1);
        for (int i = 0; i < NumReq; i++) expectBeat(2'(i), 8'(8'hB0 + i), 1'b1);
        applyStimulus();
        tick();
        tick();
        checkVal("reset_ready", 32'(bus.data_in_ready_o), 32'd0);
        checkVal("reset_valid", 32'(bus.data_out_valid_o), 32'd0);
        checkVal("reset_regs", 32'({bus.data_out_src_o, bus.data_out_o, bus.data_out_last_o}), 32'd0);

        rst = 1'b0;
        #1;
        checkVal("first_grant", 32'(bus.data_in_ready_o), 32'h1);
        tick();
        tick();
        tick();

        bus.data_out_ready_i = 1'b0;
        #1;
        checkVal("stall_valid", 32'(bus.data_out_valid_o), 32'd1);
        held = 32'({bus.data_out_src_o, bus.data_out_o, bus.data_out_last_o});
        checkVal("stall_entry_beat", held, 32'({2'd2, 8'hA2, 1'b1}));
        for (int s = 0; s < 3; s++) begin
            tick();
            checkVal("stall_hold", 32'({bus.data_out_src_o, bus.data_out_o, bus.data_out_last_o}), held);
            checkVal("stall_valid_hold", 32'(bus.data_out_valid_o), 32'd1);
            checkVal("stall_ready", 32'(bus.data_in_ready_o), 32'd0);
        end
        bus.data_out_ready_i = 1'b1;
        drain("rotation", 40);
        #1;
        checkVal("idle_ready", 32'(bus.data_in_ready_o), 32'd0);
        checkVal("idle_valid", 32'(bus.data_out_valid_o), 32'd0);

        // Move the pointer to 2, then only requesters 1 and 3 compete
        pushSrc(1, 8'h10, 1'b1);
        expectBeat(2'd1, 8'h10, 1'b1);
        applyStimulus();
        drain("ptr_setup", 20);
        pushSrc(1, 8'h11, 1'b1);
        pushSrc(1, 8'h12, 1'b1);
        pushSrc(3, 8'h31, 1'b1);
        pushSrc(3, 8'h32, 1'b1);
        expectBeat(2'd3, 8'h31, 1'b1);
        expectBeat(2'd1, 8'h11, 1'b1);
        expectBeat(2'd3, 8'h32, 1'b1);
        expectBeat(2'd1, 8'h12, 1'b1);
        applyStimulus();
        drain("sparse", 30);

        // Three-beat packet from requester 2 competing with requester 0
        pushSrc(2, 8'h21, 1'b0);
        pushSrc(2, 8'h22, 1'b0);
        pushSrc(2, 8'h23, 1'b1);
        pushSrc(0, 8'h01, 1'b1);
        pushSrc(0, 8'h02, 1'b1);
`ifdef PIPELINE_RR_ARBITER_LOCK_EN
        expectBeat(2'd2, 8'h21, 1'b0);
        expectBeat(2'd2, 8'h22, 1'b0);
        expectBeat(2'd2, 8'h23, 1'b1);
        expectBeat(2'd0, 8'h01, 1'b1);
        expectBeat(2'd0, 8'h02, 1'b1);
`else
        expectBeat(2'd2, 8'h21, 1'b0);
        expectBeat(2'd0, 8'h01, 1'b1);
        expectBeat(2'd2, 8'h22, 1'b0);
        expectBeat(2'd0, 8'h02, 1'b1);
        expectBeat(2'd2, 8'h23, 1'b1);
`endif
        lockWatch = 1'b1;
        applyStimulus();
        drain("packet", 40);
        lockWatch = 1'b0;

        // Open a packet, let a late requester wait, then reset mid-packet
        pushSrc(2, 8'h41, 1'b0);
        expectBeat(2'd2, 8'h41, 1'b0);
        applyStimulus();
        drain("lock_open", 20);
        pushSrc(3, 8'h63, 1'b1);
`ifdef PIPELINE_RR_ARBITER_LOCK_EN
        applyStimulus();
        for (int s = 0; s < 2; s++) begin
            tick();
            checkVal("late_wait_ready", 32'(bus.data_in_ready_o[3]), 32'd0);
            checkVal("late_wait_valid", 32'(bus.data_out_valid_o), 32'd0);
        end
`endif
        rst = 1'b1;
        applyStimulus();
        tick();
        checkVal("rst_lock_ready", 32'(bus.data_in_ready_o), 32'd0);
        checkVal("rst_lock_valid", 32'(bus.data_out_valid_o), 32'd0);
        checkVal("rst_lock_regs", 32'({bus.data_out_src_o, bus.data_out_o, bus.data_out_last_o}), 32'd0);
        rst = 1'b0;
        pushSrc(1, 8'h61, 1'b1);
        expectBeat(2'd1, 8'h61, 1'b1);
        expectBeat(2'd3, 8'h63, 1'b1);
        applyStimulus();
        #1;
        checkVal("post_reset_grant", 32'(bus.data_in_ready_o), 32'h2);
        drain("post_reset", 20);

        $display("[TB] directed sequence complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
